// File: rtl/param_reg_file_if.sv
// param_reg_file_if: bundles the register file's read, write and scoreboard
// signals so that ID/ALU/writeback (master) and the register file (slave)
// share one connection.
//   master: drives read/branch addresses, write ports A/B and mark_busy;
//           receives read data, busy bits and wr_collision.
//   slave : the register file side (directions mirrored).
// ADDR_WIDTH is derived from NUM_REGS and must not be overridden.
interface param_reg_file_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 8
);
  localparam int ADDR_WIDTH = $clog2(NUM_REGS);

  logic [ADDR_WIDTH-1:0] read_addr1;
  logic [ADDR_WIDTH-1:0] read_addr2;
  logic [ADDR_WIDTH-1:0] br_addr;
  logic [DATA_WIDTH-1:0] reg1_val;
  logic [DATA_WIDTH-1:0] reg2_val;
  logic [DATA_WIDTH-1:0] br_value;
  logic                  reg1_busy;
  logic                  reg2_busy;
  logic                  br_busy;
  logic                  wa_en;
  logic [ADDR_WIDTH-1:0] wa_addr;
  logic [DATA_WIDTH-1:0] wa_data;
  logic                  wb_en;
  logic [ADDR_WIDTH-1:0] wb_addr;
  logic [DATA_WIDTH-1:0] wb_data;
  logic                  mark_busy;
  logic [ADDR_WIDTH-1:0] mark_addr;
  logic                  wr_collision;

  modport master (
    output read_addr1, read_addr2, br_addr,
    output wa_en, wa_addr, wa_data,
    output wb_en, wb_addr, wb_data,
    output mark_busy, mark_addr,
    input  reg1_val, reg2_val, br_value,
    input  reg1_busy, reg2_busy, br_busy,
    input  wr_collision
  );

  modport slave (
    input  read_addr1, read_addr2, br_addr,
    input  wa_en, wa_addr, wa_data,
    input  wb_en, wb_addr, wb_data,
    input  mark_busy, mark_addr,
    output reg1_val, reg2_val, br_value,
    output reg1_busy, reg2_busy, br_busy,
    output wr_collision
  );
endinterface

// File: rtl/param_reg_file.sv
// param_reg_file: general-purpose register file with two operand read ports,
// one branch-target read port, two write ports (A: ALU, B: ID/load
// writeback) and a per-register busy scoreboard for load stalls.
// Ports:
//   clk   - single clock, all state updates on posedge
//   reset - synchronous, active-high; clears registers, busy bits and
//           wr_collision; writes/marks in a reset cycle are ignored
//   rf    - param_reg_file_if.slave: read addresses/data/busy, write ports
//           A and B, mark_busy/mark_addr, wr_collision pulse
// Parameters: DATA_WIDTH, NUM_REGS (power of 2, >= 2), ZERO_REG (1: reg 0
// is hard-wired to 0 and never busy). ADDR_WIDTH is derived.
// Optional feature macro: REGFILE_BYPASS_EN -- reads forward same-cycle
// write data (port A over port B) and show busy=0 for a register being
// cleared by port B this cycle. Undefined: reads show stored state only.
module param_reg_file #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 8,
  parameter int ZERO_REG   = 0,
  localparam int ADDR_WIDTH = $clog2(NUM_REGS)
) (
  input logic              clk,
  input logic              reset,
  param_reg_file_if.slave  rf
);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [NUM_REGS-1:0]   busy;
  logic                  wr_collision_q;

  logic wa_we;
  logic wb_we;
  logic mark_we;

  // Address 0 is untouchable when ZERO_REG is set.
  function automatic logic is_zero(input logic [ADDR_WIDTH-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // Effective (non-dropped) write/mark requests.
  always_comb begin
    wa_we   = rf.wa_en     && !is_zero(rf.wa_addr);
    wb_we   = rf.wb_en     && !is_zero(rf.wb_addr);
    mark_we = rf.mark_busy && !is_zero(rf.mark_addr);
  end

  // Port B is written before port A so that A wins on a shared address;
  // likewise the busy clear precedes the set so that a new mark wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      regs           <= '{default: '0};
      busy           <= '0;
      wr_collision_q <= 1'b0;
    end else begin
      if (wb_we) regs[rf.wb_addr] <= rf.wb_data;
      if (wa_we) regs[rf.wa_addr] <= rf.wa_data;
      if (wb_we)   busy[rf.wb_addr]   <= 1'b0;
      if (mark_we) busy[rf.mark_addr] <= 1'b1;
      wr_collision_q <= wa_we && wb_we && (rf.wa_addr == rf.wb_addr);
    end
  end

`ifdef REGFILE_BYPASS_EN
  // Forwarding only reflects writes that will actually land, so a reset
  // cycle forwards nothing.
  logic wa_fwd;
  logic wb_fwd;
  logic wb_clr;

  always_comb begin
    wa_fwd = wa_we && !reset;
    wb_fwd = wb_we && !reset;
    // A simultaneous mark of the same register keeps it busy.
    wb_clr = wb_fwd && !(mark_we && (rf.mark_addr == rf.wb_addr));
  end
`endif

  function automatic logic [DATA_WIDTH-1:0] read_data(
    input logic [ADDR_WIDTH-1:0] a
  );
    logic [DATA_WIDTH-1:0] d;
    d = regs[a];
`ifdef REGFILE_BYPASS_EN
    if (wa_fwd && (rf.wa_addr == a)) begin
      d = rf.wa_data;
    end else if (wb_fwd && (rf.wb_addr == a)) begin
      d = rf.wb_data;
    end
`endif
    if (is_zero(a)) d = '0;
    return d;
  endfunction

  function automatic logic read_busy(input logic [ADDR_WIDTH-1:0] a);
    logic b;
    b = busy[a];
`ifdef REGFILE_BYPASS_EN
    if (wb_clr && (rf.wb_addr == a)) b = 1'b0;
`endif
    if (is_zero(a)) b = 1'b0;
    return b;
  endfunction

  always_comb begin
    rf.reg1_val     = read_data(rf.read_addr1);
    rf.reg2_val     = read_data(rf.read_addr2);
    rf.br_value     = read_data(rf.br_addr);
    rf.reg1_busy    = read_busy(rf.read_addr1);
    rf.reg2_busy    = read_busy(rf.read_addr2);
    rf.br_busy      = read_busy(rf.br_addr);
    rf.wr_collision = wr_collision_q;
  end

endmodule

// File: tb/tb_param_reg_file.sv
// tb_param_reg_file: self-checking bench for param_reg_file (ZERO_REG=1,
// 8 x 32-bit). Random traffic is checked against an array-based reference
// model, followed by directed checks of reset, write latency, collision,
// scoreboard, zero register and reset-while-busy behaviour.
module tb_param_reg_file;
  localparam int DW = 32;
  localparam int NR = 8;
  localparam int AW = $clog2(NR);
  localparam int ZR = 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  param_reg_file_if #(.DATA_WIDTH(DW), .NUM_REGS(NR)) ifc ();

  param_reg_file #(.DATA_WIDTH(DW), .NUM_REGS(NR), .ZERO_REG(ZR)) dut (
    .clk   (clk),
    .reset (reset),
    .rf    (ifc.slave)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [DW-1:0] m_reg  [NR];
  logic          m_busy [NR];
  logic          m_coll;

  task automatic chk(input string tag, input logic [DW-1:0] obs,
                     input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit dropped(input int a);
    return (ZR != 0) && (a == 0);
  endfunction

  function automatic logic [DW-1:0] m_read(input int a);
    if (dropped(a)) return '0;
`ifdef REGFILE_BYPASS_EN
    if (!reset && ifc.wa_en && int'(ifc.wa_addr) == a) return ifc.wa_data;
    if (!reset && ifc.wb_en && int'(ifc.wb_addr) == a) return ifc.wb_data;
`endif
    return m_reg[a];
  endfunction

  function automatic logic m_rbusy(input int a);
    if (dropped(a)) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (!reset && ifc.wb_en && int'(ifc.wb_addr) == a &&
        !(ifc.mark_busy && int'(ifc.mark_addr) == a)) return 1'b0;
`endif
    return m_busy[a];
  endfunction

  // Advance one clock and apply the same edge to the model.
  task automatic tick();
    int wa, wb, mk;
    @(posedge clk);
    wa = int'(ifc.wa_addr);
    wb = int'(ifc.wb_addr);
    mk = int'(ifc.mark_addr);
    if (reset) begin
      for (int i = 0; i < NR; i++) begin
        m_reg[i]  = '0;
        m_busy[i] = 1'b0;
      end
      m_coll = 1'b0;
    end else begin
      m_coll = ifc.wa_en && ifc.wb_en && wa == wb && !dropped(wa);
      if (ifc.wb_en && !dropped(wb)) begin
        m_reg[wb]  = ifc.wb_data;
        m_busy[wb] = 1'b0;
      end
      if (ifc.wa_en && !dropped(wa)) m_reg[wa] = ifc.wa_data;
      if (ifc.mark_busy && !dropped(mk)) m_busy[mk] = 1'b1;
    end
    #1;
  endtask

  task automatic idle();
    reset          = 1'b0;
    ifc.wa_en      = 1'b0;
    ifc.wb_en      = 1'b0;
    ifc.mark_busy  = 1'b0;
    ifc.wa_addr    = '0;
    ifc.wb_addr    = '0;
    ifc.mark_addr  = '0;
    ifc.wa_data    = '0;
    ifc.wb_data    = '0;
  endtask

  task automatic check_model();
    chk("rand_reg1_val",  ifc.reg1_val,  m_read(int'(ifc.read_addr1)));
    chk("rand_reg2_val",  ifc.reg2_val,  m_read(int'(ifc.read_addr2)));
    chk("rand_br_value",  ifc.br_value,  m_read(int'(ifc.br_addr)));
    chk("rand_reg1_busy", DW'(ifc.reg1_busy), DW'(m_rbusy(int'(ifc.read_addr1))));
    chk("rand_reg2_busy", DW'(ifc.reg2_busy), DW'(m_rbusy(int'(ifc.read_addr2))));
    chk("rand_br_busy",   DW'(ifc.br_busy),   DW'(m_rbusy(int'(ifc.br_addr))));
    chk("rand_wr_collision", DW'(ifc.wr_collision), DW'(m_coll));
  endtask

  initial begin
    idle();
    ifc.read_addr1 = '0;
    ifc.read_addr2 = '0;
    ifc.br_addr    = '0;
    reset = 1'b1;
    tick();
    reset = 1'b0;

    // Random traffic with occasional resets; narrow address range raises
    // the chance of collisions and mark/clear overlaps.
    for (int n = 0; n < 400; n++) begin
      reset          = ($urandom_range(0, 29) == 0);
      ifc.wa_en      = $urandom_range(0, 1) == 1;
      ifc.wb_en      = $urandom_range(0, 1) == 1;
      ifc.mark_busy  = $urandom_range(0, 2) == 0;
      ifc.wa_addr    = AW'($urandom_range(0, NR - 1));
      ifc.wb_addr    = AW'($urandom_range(0, NR - 1));
      ifc.mark_addr  = AW'($urandom_range(0, NR - 1));
      ifc.wa_data    = $urandom;
      ifc.wb_data    = $urandom;
      ifc.read_addr1 = AW'($urandom_range(0, NR - 1));
      ifc.read_addr2 = AW'($urandom_range(0, NR - 1));
      ifc.br_addr    = AW'($urandom_range(0, NR - 1));
      #1;
      check_model();
      tick();
    end

    // 1: reset after random writes clears everything
    ifc.wa_en = 1'b1; ifc.wa_addr = AW'(4); ifc.wa_data = 32'h1234_5678;
    ifc.wb_en = 1'b1; ifc.wb_addr = AW'(4); ifc.wb_data = 32'h8765_4321;
    ifc.mark_busy = 1'b1; ifc.mark_addr = AW'(7);
    reset = 1'b1;
    tick();
    idle();
    for (int a = 0; a < NR; a += 3) begin
      ifc.read_addr1 = AW'(a);
      ifc.read_addr2 = AW'(a + 1);
      ifc.br_addr    = AW'(a + 2);
      #1;
      chk("rst_reg1_val", ifc.reg1_val, '0);
      chk("rst_reg2_val", ifc.reg2_val, '0);
      chk("rst_br_value", ifc.br_value, '0);
      chk("rst_busy", DW'({ifc.reg1_busy, ifc.reg2_busy, ifc.br_busy}), '0);
    end
    chk("rst_wr_collision", DW'(ifc.wr_collision), '0);

    // 2: write then read
    ifc.wa_en = 1'b1; ifc.wa_addr = AW'(3); ifc.wa_data = 32'hDEAD_BEEF;
    ifc.read_addr1 = AW'(3);
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("bypass_same_cycle", ifc.reg1_val, 32'hDEAD_BEEF);
`else
    chk("no_bypass_same_cycle", ifc.reg1_val, '0);
`endif
    tick();
    idle();
    #1;
    chk("write_read_next", ifc.reg1_val, 32'hDEAD_BEEF);

    // 3: collision on address 5
    ifc.wa_en = 1'b1; ifc.wa_addr = AW'(5); ifc.wa_data = 32'h11;
    ifc.wb_en = 1'b1; ifc.wb_addr = AW'(5); ifc.wb_data = 32'h22;
    tick();
    idle();
    ifc.read_addr1 = AW'(5);
    #1;
    chk("coll_a_wins", ifc.reg1_val, 32'h11);
    chk("coll_pulse", DW'(ifc.wr_collision), 32'h1);
    tick();
    chk("coll_pulse_end", DW'(ifc.wr_collision), '0);

    // 4: scoreboard on reg 2
    ifc.read_addr2 = AW'(2);
    ifc.mark_busy = 1'b1; ifc.mark_addr = AW'(2);
    tick();
    idle();
    #1;
    chk("sb_marked", DW'(ifc.reg2_busy), 32'h1);
    ifc.mark_busy = 1'b1; ifc.mark_addr = AW'(2);
    ifc.wb_en = 1'b1; ifc.wb_addr = AW'(2); ifc.wb_data = 32'h7;
    #1;
    chk("sb_set_wins_same_cycle", DW'(ifc.reg2_busy), 32'h1);
    tick();
    idle();
    #1;
    chk("sb_set_wins", DW'(ifc.reg2_busy), 32'h1);
    chk("sb_data", ifc.reg2_val, 32'h7);
    ifc.wb_en = 1'b1; ifc.wb_addr = AW'(2); ifc.wb_data = 32'h7;
    tick();
    idle();
    #1;
    chk("sb_cleared", DW'(ifc.reg2_busy), '0);

    // 5: zero register
    ifc.wa_en = 1'b1; ifc.wa_addr = '0; ifc.wa_data = 32'hFFFF_FFFF;
    ifc.wb_en = 1'b1; ifc.wb_addr = '0; ifc.wb_data = 32'hAAAA_5555;
    ifc.mark_busy = 1'b1; ifc.mark_addr = '0;
    ifc.read_addr1 = '0;
    #1;
    chk("zero_same_cycle", ifc.reg1_val, '0);
    tick();
    idle();
    #1;
    chk("zero_val", ifc.reg1_val, '0);
    chk("zero_busy", DW'(ifc.reg1_busy), '0);
    chk("zero_no_collision", DW'(ifc.wr_collision), '0);

    // 6: reset while busy
    ifc.br_addr = AW'(6);
    ifc.mark_busy = 1'b1; ifc.mark_addr = AW'(6);
    tick();
    idle();
    #1;
    chk("rb_marked", DW'(ifc.br_busy), 32'h1);
    reset = 1'b1;
    tick();
    idle();
    #1;
    chk("rb_after_reset", DW'(ifc.br_busy), '0);
    ifc.wb_en = 1'b1; ifc.wb_addr = AW'(6); ifc.wb_data = 32'hCAFE_0006;
    tick();
    idle();
    #1;
    chk("rb_after_write", DW'(ifc.br_busy), '0);
    chk("rb_value", ifc.br_value, 32'hCAFE_0006);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
